// File: rtl/stoch_ctrl_pkg.sv
// Shared state encoding for the stochastic-network window controllers.
package stoch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_RUN   = 3'd3,
        ST_LATCH = 3'd4,
        ST_DONE  = 3'd5
    } ctrl_state_e;

    localparam int CTRL_STATE_W = 3;

endpackage

// File: rtl/win_counter.sv
// Window sample counter: cleared per window, counts enabled cycles and flags
// the cycle on which the final sample of the window is being taken.
module win_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] term,
    output logic         done
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // term is never zero here, so term-1 is the count held during the last sample
    assign done = enable && (count_q == (term - ONE));

endmodule

// File: rtl/mean_window_ctrl.sv
// Sequencer for the stochastic mean accumulators: INIT/RESET/ENABLE/preRESET
// strobes per window, with completed-window counting and halt/pause handling.
module mean_window_ctrl
    import stoch_ctrl_pkg::*;
#(
    parameter int N_Count = 8,
    parameter int EPOCH_W = 16
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               GO,
    input  logic               CONT,
    input  logic               HALT,
    input  logic               PAUSE,
    input  logic               DO_INIT,
    input  logic [N_Count-1:0] WIN_LEN,
    output logic               INIT,
    output logic               RESET,
    output logic               preRESET,
    output logic               ENABLE,
    output logic               BUSY,
    output logic               VALID,
    output logic [EPOCH_W-1:0] EPOCH
);

    localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);

    ctrl_state_e        state_q, state_d;
    logic [N_Count-1:0] len_q, len_d;
    logic               halt_q, halt_d;
    logic               armed_q, armed_d;
    logic               init_q, init_d;
    logic               clr_q, clr_d;
    logic               pre_q, pre_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               go_ok;
    logic               win_clear;
    logic               win_done;

    // GO is only honoured once a full clock has passed in IDLE after reset
    assign go_ok     = GO && armed_q;
    assign win_clear = (state_q == ST_CLEAR);

    win_counter #(
        .W(N_Count)
    ) u_win_counter (
        .clk   (CLK),
        .rst_n (RESET_N),
        .clear (win_clear),
        .enable(en_q),
        .term  (len_q),
        .done  (win_done)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            halt_q  <= 1'b0;
            armed_q <= 1'b0;
            init_q  <= 1'b0;
            clr_q   <= 1'b0;
            pre_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            epoch_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            halt_q  <= halt_d;
            armed_q <= armed_d;
            init_q  <= init_d;
            clr_q   <= clr_d;
            pre_q   <= pre_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            epoch_q <= epoch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        armed_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (go_ok) begin
                    state_d = DO_INIT ? ST_INIT : ST_CLEAR;
                    // a zero length means the longest window the sum can hold
                    len_d   = (WIN_LEN == '0) ? '1 : WIN_LEN;
                end
            end
            ST_INIT:  state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_RUN;
            ST_RUN: begin
                if (win_done) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: state_d = ST_DONE;
            ST_DONE:  state_d = (CONT && !(halt_q || HALT)) ? ST_CLEAR : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        halt_d = halt_q;
        if (state_d == ST_IDLE) begin
            halt_d = 1'b0;
        end else if (HALT) begin
            halt_d = 1'b1;
        end
    end

    // Strobes are decoded from the next state so every output comes straight off a flop
    always_comb begin
        init_d  = (state_d == ST_INIT);
        clr_d   = (state_d == ST_CLEAR);
        pre_d   = (state_d == ST_LATCH);
        en_d    = (state_d == ST_RUN) && !PAUSE;
        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_DONE);
        epoch_d = valid_d ? (epoch_q + EPOCH_ONE) : epoch_q;
    end

    assign INIT     = init_q;
    assign RESET    = clr_q;
    assign preRESET = pre_q;
    assign ENABLE   = en_q;
    assign BUSY     = busy_q;
    assign VALID    = valid_q;
    assign EPOCH    = epoch_q;

endmodule

// File: tb/tb_mean_window_ctrl.sv
// Directed bench for mean_window_ctrl: per-cycle strobe traces written as
// character patterns, plus a monitor for strobe exclusivity and window length.
module tb_mean_window_ctrl;

    logic        CLK;
    logic        RESET_N;
    logic        GO, CONT, HALT, PAUSE, DO_INIT;
    logic [7:0]  WIN_LEN;

    logic        init_o, reset_o, pre_o, en_o, busy_o, valid_o;
    logic [15:0] epoch_o;
    logic        init4_o, reset4_o, pre4_o, en4_o, busy4_o, valid4_o;
    logic [15:0] epoch4_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_len      = 0;
    int en_count     = 0;
    int busy_seen    = 0;

    mean_window_ctrl #(.N_Count(8), .EPOCH_W(16)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .GO      (GO),
        .CONT    (CONT),
        .HALT    (HALT),
        .PAUSE   (PAUSE),
        .DO_INIT (DO_INIT),
        .WIN_LEN (WIN_LEN),
        .INIT    (init_o),
        .RESET   (reset_o),
        .preRESET(pre_o),
        .ENABLE  (en_o),
        .BUSY    (busy_o),
        .VALID   (valid_o),
        .EPOCH   (epoch_o)
    );

    // Narrow instance used for the zero-length window case
    mean_window_ctrl #(.N_Count(4), .EPOCH_W(16)) dut4 (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .GO      (GO),
        .CONT    (CONT),
        .HALT    (HALT),
        .PAUSE   (PAUSE),
        .DO_INIT (DO_INIT),
        .WIN_LEN (WIN_LEN[3:0]),
        .INIT    (init4_o),
        .RESET   (reset4_o),
        .preRESET(pre4_o),
        .ENABLE  (en4_o),
        .BUSY    (busy4_o),
        .VALID   (valid4_o),
        .EPOCH   (epoch4_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Pattern letters: I=INIT R=RESET E=ENABLE P=preRESET V=VALID p=paused RUN -=idle
    function automatic logic [5:0] codeOf(input byte c);
        case (c)
            "I":     return 6'b110000;
            "R":     return 6'b101000;
            "P":     return 6'b100100;
            "E":     return 6'b100010;
            "V":     return 6'b100001;
            "p":     return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [5:0] observed();
        return {busy_o, init_o, reset_o, pre_o, en_o, valid_o};
    endfunction

    task automatic expectTrace(input string tag, input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            checkOutput($sformatf("%s[%0d]", tag, i), 32'(observed()), 32'(codeOf(pat[i])));
            if (busy_o) busy_seen++;
            @(negedge CLK);
        end
    endtask

    task automatic applyStimulus(input logic go, input logic cont, input logic halt,
                                 input logic pause, input logic do_init, input logic [7:0] win_len);
        GO      = go;
        CONT    = cont;
        HALT    = halt;
        PAUSE   = pause;
        DO_INIT = do_init;
        WIN_LEN = win_len;
    endtask

    task automatic resetDut(input string tag);
        RESET_N = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (2) @(negedge CLK);
        checkOutput({tag, " reset outputs"}, 32'(observed()), 32'd0);
        checkOutput({tag, " reset epoch"}, 32'(epoch_o), 32'd0);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    // Every cycle: strobes mutually exclusive on both instances, and each
    // latched window must have seen exactly the expected number of samples
    always @(negedge CLK) begin
        checkOutput("strobes exclusive", ($countones({init_o, reset_o, pre_o, en_o}) > 1) ? 32'd1 : 32'd0, 32'd0);
        checkOutput("strobes exclusive n4", ($countones({init4_o, reset4_o, pre4_o, en4_o}) > 1) ? 32'd1 : 32'd0, 32'd0);
        if (reset_o) en_count = 0;
        else if (en_o) en_count++;
        if (pre_o) checkOutput("window length", 32'(en_count), 32'(exp_len));
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int en4;
        int pre4;
        int pv_seen;

        RESET_N = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Single window with INIT, GO re-asserted mid-run is ignored
        resetDut("t1");
        exp_len   = 4;
        busy_seen = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4);
        @(negedge CLK);
        GO = 1'b0;
        expectTrace("t1a", "IRE");
        GO = 1'b1;
        expectTrace("t1b", "E");
        GO = 1'b0;
        expectTrace("t1c", "EEPV-");
        checkOutput("t1 busy cycles", 32'(busy_seen), 32'd8);
        checkOutput("t1 epoch", 32'(epoch_o), 32'd1);

        // Continuous windows, HALT in IDLE ignored, WIN_LEN change mid-run ignored, HALT in window 3
        resetDut("t2");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        @(negedge CLK);
        HALT = 1'b0;
        expectTrace("t2 idle", "-");
        exp_len = 3;
        GO = 1'b1;
        @(negedge CLK);
        GO = 1'b0;
        WIN_LEN = 8'd7;
        expectTrace("t2a", "REEEPVREEEPVRE");
        HALT = 1'b1;
        expectTrace("t2b", "E");
        HALT = 1'b0;
        expectTrace("t2c", "EPV--");
        checkOutput("t2 epoch", 32'(epoch_o), 32'd3);

        // Two paused cycles stretch RUN to 7 cycles with 5 samples
        resetDut("t3");
        exp_len = 5;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
        @(negedge CLK);
        GO = 1'b0;
        expectTrace("t3a", "REE");
        PAUSE = 1'b1;
        expectTrace("t3b", "Ep");
        PAUSE = 1'b0;
        expectTrace("t3c", "pEEPV-");
        checkOutput("t3 epoch", 32'(epoch_o), 32'd1);

        // Zero length: 15 samples on the 4-bit instance, 255 on the 8-bit one
        resetDut("t4");
        exp_len = 255;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        @(negedge CLK);
        GO   = 1'b0;
        en4  = 0;
        pre4 = 0;
        for (int i = 0; i < 600 && busy_o; i++) begin
            if (en4_o) en4++;
            if (pre4_o) pre4++;
            @(negedge CLK);
        end
        checkOutput("t4 n4 enables", 32'(en4), 32'd15);
        checkOutput("t4 n4 latches", 32'(pre4), 32'd1);
        checkOutput("t4 n4 epoch", 32'(epoch4_o), 32'd1);
        checkOutput("t4 idle in budget", 32'(busy_o), 32'd0);
        checkOutput("t4 epoch", 32'(epoch_o), 32'd1);

        // Reset mid-window after two samples, then a clean restart
        resetDut("t5");
        exp_len = 6;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6);
        @(negedge CLK);
        GO = 1'b0;
        expectTrace("t5a", "IREE");
        RESET_N = 1'b0;
        #1;
        checkOutput("t5 abort outputs", 32'(observed()), 32'd0);
        checkOutput("t5 abort epoch", 32'(epoch_o), 32'd0);
        pv_seen = 0;
        repeat (3) begin
            @(negedge CLK);
            if (pre_o || valid_o) pv_seen++;
        end
        RESET_N = 1'b1;
        @(negedge CLK);
        expectTrace("t5 idle", "--");
        checkOutput("t5 no latch after abort", 32'(pv_seen), 32'd0);
        exp_len = 2;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
        @(negedge CLK);
        GO = 1'b0;
        expectTrace("t5b", "REEPV-");
        checkOutput("t5 epoch", 32'(epoch_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
